// File: rtl/uart_rx_sampler.sv
// Serial-side datapath of the UART receiver: synchronises rx_serial, flags the start
// edge while idle, and times/samples one frame (start, data LSB-first, parity, stop).
module uart_rx_sampler #(
  parameter int BAUD_DIV   = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 rx_start,
  output logic                 start_detected,
  output logic                 rx_done,
  output logic                 parity_error,
  output logic                 stop_bit_error,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [2:0]           state_dbg
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_CHK = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 hist_q, hist_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 start_det_q, start_det_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 serr_q, serr_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  always_comb begin
    state_d     = state_q;
    sync1_d     = rx_serial;
    sync2_d     = sync1_q;
    hist_d      = sync2_q;
    baud_d      = baud_q + 1'b1;
    bit_d       = bit_q;
    start_det_d = 1'b0;
    done_d      = 1'b0;
    perr_d      = perr_q;
    serr_d      = serr_q;
    data_d      = data_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (hist_q && !sync2_q) start_det_d = 1'b1;
        if (rx_start) begin
          state_d = S_START_CHK;
          perr_d  = 1'b0;
          serr_d  = 1'b0;
        end
      end
      S_START_CHK: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          if (!sync2_q) begin
            state_d = S_DATA;
          end else begin
            // Line went back high before mid start bit: report as a framing fault
            // so the controller is not left waiting for a frame that never comes.
            state_d = S_DONE;
            serr_d  = 1'b1;
            perr_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (baud_q == FULL_LAST) begin
          baud_d = '0;
          data_d = {sync2_q, data_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = S_PARITY;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_q == FULL_LAST) begin
          baud_d  = '0;
          perr_d  = ((^data_q) ^ sync2_q) != PAR_ODD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_q == FULL_LAST) begin
          baud_d  = '0;
          serr_d  = !sync2_q;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      hist_q      <= 1'b1;
      baud_q      <= '0;
      bit_q       <= '0;
      start_det_q <= 1'b0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      start_det_q <= start_det_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
      data_q      <= data_d;
    end
  end

  assign start_detected = start_det_q;
  assign rx_done        = done_q;
  assign parity_error   = perr_q;
  assign stop_bit_error = serr_q;
  assign rx_data        = data_q;
  assign state_dbg      = state_q;

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Serial-side datapath of the UART receiver. It synchronises the `rx_serial` line, flags the falling edge of a start bit, and runs the over-sampled bit timing for one frame. A frame is start, `DATA_BITS` data bits LSB-first, one parity bit, and one stop bit. The block shifts in the data, checks parity and stop, and reports the outcome to the receive controller FSM, which then decides whether to store the byte.

## Interface
Parameters:
- `BAUD_DIV`, 16, clk cycles per bit period; even, ≥ 4
- `DATA_BITS`, 8, data bits per frame; range 5–9
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `rx_serial`  in  1  asynchronous serial line; idles high
- `rx_start`  in  1  one-cycle pulse from the controller; launches frame reception
- `start_detected`  out  1  one-cycle pulse on a start-bit falling edge while idle
- `rx_done`  out  1  one-cycle pulse; frame finished or aborted
- `parity_error`  out  1  parity mismatch; valid from `rx_done`
- `stop_bit_error`  out  1  stop bit sampled 0, or false start; valid from `rx_done`
- `rx_data`  out  `DATA_BITS`  received data; valid from `rx_done`

## Operation
- **Synchroniser.** Two-flop synchroniser on `rx_serial`, followed by one history flop for edge detection. All three flops reset to 1.
- **States:** IDLE, START_CHK, DATA, PARITY, STOP, DONE.
- **Counters.**
  - Baud counter: `$clog2(BAUD_DIV)` bits.
  - Bit counter: `$clog2(DATA_BITS+1)` bits.
  - Both clear on every state entry.
- **IDLE**
  - `start_detected` = 1 for one cycle when history = 1 and synced = 0.
  - Edge detection runs in IDLE only.
  - `rx_start` moves the block to START_CHK; baud counter cleared.
  - Without `rx_start` the block stays in IDLE. It re-flags only on a new falling edge.
- **START_CHK**
  - Sample when the baud counter reaches `BAUD_DIV/2-1` (mid start bit).
  - Sample = 0: go to DATA.
  - Sample = 1 (glitch): go to DONE with `stop_bit_error`=1 and `parity_error`=0. This keeps the controller from waiting forever.
- **DATA**
  - Sample when the baud counter reaches `BAUD_DIV-1`, then restart the counter.
  - Shift right; the new bit enters at the MSB, so after `DATA_BITS` shifts bit 0 is the first bit received.
  - After `DATA_BITS` samples, go to PARITY.
- **PARITY**
  - Sample at `BAUD_DIV-1`.
  - `parity_error` = (XOR of all data bits XOR parity bit) != `PARITY_ODD`.
  - Go to STOP.
- **STOP**
  - Sample at `BAUD_DIV-1`.
  - `stop_bit_error` = inverse of the sampled bit.
  - Go to DONE.
- **DONE**
  - `rx_done` = 1 for exactly one cycle, then return to IDLE.
  - Edge detection is live again from the following cycle. The line sits mid stop bit at that point, so the next start edge is caught.
- **Output holding.** `rx_data`, `parity_error` and `stop_bit_error` are registered. They hold from the DONE cycle until the next accepted `rx_start`, which clears both error flags; `rx_data` is overwritten by the next frame's shifts.
- **Ignored input.** `rx_start` outside IDLE has no effect.
- **Reset values.** `start_detected`=0, `rx_done`=0, `parity_error`=0, `stop_bit_error`=0, `rx_data`=0, state IDLE.
- **Reset mid-frame.** Reset aborts the frame with no `rx_done`. The block is ready again the cycle after reset deasserts.

## Timing
- Let T be the cycle in which `rx_start` is sampled high.
- Start-bit sample: cycle T + `BAUD_DIV/2`.
- Data bit i sample (i = 0 … `DATA_BITS-1`): `BAUD_DIV*(i+1)` cycles after the start sample.
- Parity sample: `BAUD_DIV*(DATA_BITS+1)` cycles after the start sample.
- Stop sample: `BAUD_DIV*(DATA_BITS+2)` cycles after the start sample.
- `rx_done`: one cycle after the stop sample, i.e. cycle T + `BAUD_DIV/2` + `BAUD_DIV*(DATA_BITS+2)` + 1. This count is exact.
- False-start `rx_done`: cycle T + `BAUD_DIV/2` + 1.
- `start_detected`: 2–3 cycles after the line edge (synchroniser latency). The controller's `rx_start` follows 1 cycle later. This offset is included in the half-bit centring tolerance.
- `rx_data` and both flags are stable from the `rx_done` cycle onward. The controller's STORE cycle therefore sees valid data.

## Test plan
All scenarios use `BAUD_DIV`=16, `DATA_BITS`=8, `PARITY_ODD`=0, with a controller model that returns `rx_start` 1 cycle after `start_detected`.
- **Clean frame:** send 0xA5 LSB-first, parity 0, stop 1 → `rx_data`=0xA5, both flags 0, `rx_done` exactly 169 cycles after `rx_start`.
- **Parity error:** send 0xA5 with parity bit 1 → `parity_error`=1, `stop_bit_error`=0, `rx_data`=0xA5.
- **Framing error:** send 0x3C with correct parity 0 and stop bit 0 → `stop_bit_error`=1, `parity_error`=0.
- **Glitch:** drive the line low for 3 cycles, then high → one `start_detected` pulse; `rx_done` 9 cycles after `rx_start` with `stop_bit_error`=1, `parity_error`=0; then back in IDLE.
- **Reset mid-frame:** pulse `reset` during data bit 3 → all outputs 0 and no `rx_done`; the next frame 0x3C is then received cleanly.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap → two `rx_done` pulses, data 0x00 then 0xFF, no errors; flags cleared by the second `rx_start`.
